frame_streamer: RTL and testbench

Raster-order pixel source for the HOG front end. On `start` it reads one frame from a synchronous-read frame memory and streams it out on a valid/ready pixel interface, one pixel per cycle when downstream is ready. Its output connects directly to the pixel input of `gaussian_filter` or `lin_buff`. A 2-entry skid FIFO hides the memory read latency and absorbs backpressure.

---
 rtl/frame_streamer.sv | 107 ++++++++++
 tb/tb_frame_streamer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_streamer.sv
// frame_streamer: reads a frame from synchronous-read memory and streams it in raster order.
// Define FRAME_STREAMER_MARKERS_EN to carry sof/eol tags alongside each pixel.
module frame_streamer #(
    parameter int DATA_WIDTH   = 8,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int ADDR_WIDTH   = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] pixel,
    output logic                  sof,
    output logic                  eol
);
    localparam int TOTAL = IMAGE_WIDTH * IMAGE_HEIGHT;
`ifdef FRAME_STREAMER_MARKERS_EN
    localparam int FW = DATA_WIDTH + 2;
`else
    localparam int FW = DATA_WIDTH;
`endif
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
    state_t state;
    logic [FW-1:0] e0, e1, din;
    logic [1:0] occ;
    logic inflight, pop, push, last;
    assign out_valid = occ != 2'd0;
    assign pop = out_valid && out_ready;
    assign push = inflight;
    assign last = mem_addr == ADDR_WIDTH'(TOTAL - 1);
    // Reads in flight count against FIFO space, so the 2 entries can never overflow.
    assign mem_rd_en = state == STREAM && ({1'b0, occ} + {2'b0, inflight} - {2'b0, pop} < 3'd2);
    assign pixel = e0[DATA_WIDTH-1:0];
`ifdef FRAME_STREAMER_MARKERS_EN
    localparam int XW = $clog2(IMAGE_WIDTH + 1);
    localparam int YW = $clog2(IMAGE_HEIGHT + 1);
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic sof_q, eol_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x <= '0;
            y <= '0;
            sof_q <= 1'b0;
            eol_q <= 1'b0;
        end else begin
            sof_q <= x == '0 && y == '0;
            eol_q <= x == XW'(IMAGE_WIDTH - 1);
            if (state == IDLE && start) begin
                x <= '0;
                y <= '0;
            end else if (mem_rd_en) begin
                x <= x == XW'(IMAGE_WIDTH - 1) ? '0 : x + 1'b1;
                y <= x == XW'(IMAGE_WIDTH - 1) ? y + 1'b1 : y;
            end
        end
    end
    assign din = {sof_q, eol_q, mem_rd_data};
    assign sof = out_valid && e0[FW-1];
    assign eol = out_valid && e0[FW-2];
`else
    assign din = mem_rd_data;
    assign sof = 1'b0;
    assign eol = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            mem_addr <= '0;
            inflight <= 1'b0;
            occ <= 2'd0;
            e0 <= '0;
            e1 <= '0;
        end else begin
            inflight <= mem_rd_en;
            done <= 1'b0;
            if (mem_rd_en) mem_addr <= mem_addr + 1'b1;
            case (state)
                IDLE: if (start) begin
                    state <= STREAM;
                    busy <= 1'b1;
                    mem_addr <= '0;
                end
                STREAM: if (mem_rd_en && last) state <= DRAIN;
                DRAIN: if (pop && occ == 2'd1 && !inflight) begin
                    state <= DONE;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            occ <= occ + {1'b0, push} - {1'b0, pop};
            if (push && (occ == 2'd0 || (occ == 2'd1 && pop))) e0 <= din;
            else if (pop) e0 <= e1;
            if (push && ((occ == 2'd1 && !pop) || occ == 2'd2)) e1 <= din;
        end
    end
endmodule

// File: tb/tb_frame_streamer.sv
// tb_frame_streamer: randomized and directed frame streaming against a raster-order reference.
module tb_frame_streamer;
    localparam int DW = 8, W = 4, H = 3, AW = 4, N = W * H;
`ifdef FRAME_STREAMER_MARKERS_EN
    localparam bit MK = 1'b1;
`else
    localparam bit MK = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic busy, done, mem_rd_en, out_valid, sof, eol;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data, pixel;
    logic [DW-1:0] mem [2**AW];
    int checks = 0, errors = 0;

    frame_streamer #(.DATA_WIDTH(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .pixel(pixel), .sof(sof), .eol(eol)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    function automatic bit exp_sof(int k);
        return MK && k == 0;
    endfunction
    function automatic bit exp_eol(int k);
        return MK && (k % W) == W - 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy, done, mem_rd_en, out_valid, sof, eol, mem_addr, pixel} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {busy, done, mem_rd_en, out_valid, sof, eol, mem_addr, pixel});
        end
        tick();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            checks++;
            if ({busy, mem_rd_en, out_valid} !== 3'b000) begin
                errors++;
                $display("FAIL idle_quiet: got %b expected 000", {busy, mem_rd_en, out_valid});
            end
        end
    endtask

    task automatic test_full_speed();
        int k = 0, dn = 0, dc = -1;
        for (int c = 0; c < 20; c++) begin
            tick();
            start = c == 0;
            out_ready = 1'b1;
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (!(mem_rd_en === 1'b1 && mem_addr === '0)) begin
                    errors++;
                    $display("FAIL fs_first_read: got en=%b addr=%0d expected en=1 addr=0", mem_rd_en, mem_addr);
                end
            end
            checks++;
            if (out_valid !== (c >= 3 && c <= 14)) begin
                errors++;
                $display("FAIL fs_valid c=%0d: got %b expected %b", c, out_valid, c >= 3 && c <= 14);
            end
            checks++;
            if (busy !== (c >= 1 && c <= 14)) begin
                errors++;
                $display("FAIL fs_busy c=%0d: got %b expected %b", c, busy, c >= 1 && c <= 14);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (pixel !== DW'(k) || sof !== exp_sof(k) || eol !== exp_eol(k) || c != 3 + k) begin
                    errors++;
                    $display("FAIL fs_pixel c=%0d: got pix=%0d sof=%b eol=%b expected pix=%0d sof=%b eol=%b at c=%0d",
                             c, pixel, sof, eol, k, exp_sof(k), exp_eol(k), 3 + k);
                end
                k++;
            end
            if (done === 1'b1) begin
                dn++;
                dc = c;
            end
        end
        checks++;
        if (k != N || dn != 1 || dc != 15) begin
            errors++;
            $display("FAIL fs_frame_end: got pixels=%0d dones=%0d done_cycle=%0d expected 12 1 15", k, dn, dc);
        end
    endtask

    task automatic test_backpressure();
        int k = 0, issued = 0, last_hs = -1, dc = -1;
        bit pstall = 0, psof = 0, peol = 0;
        logic [DW-1:0] ppix = '0;
        for (int c = 0; c < 300 && dc < 0; c++) begin
            tick();
            start = c == 0;
            out_ready = $urandom_range(1, 0) == 1;
            @(negedge clk);
            if (pstall) begin
                checks++;
                if (out_valid !== 1'b1 || pixel !== ppix || sof !== psof || eol !== peol) begin
                    errors++;
                    $display("FAIL bp_stable c=%0d: got v=%b pix=%0d expected v=1 pix=%0d", c, out_valid, pixel, ppix);
                end
            end
            if (mem_rd_en) begin
                checks++;
                if (mem_addr !== AW'(issued)) begin
                    errors++;
                    $display("FAIL bp_addr: got %0d expected %0d", mem_addr, issued);
                end
                issued++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (pixel !== DW'(k) || sof !== exp_sof(k) || eol !== exp_eol(k)) begin
                    errors++;
                    $display("FAIL bp_pixel: got pix=%0d sof=%b eol=%b expected pix=%0d sof=%b eol=%b",
                             pixel, sof, eol, k, exp_sof(k), exp_eol(k));
                end
                k++;
                last_hs = c;
            end
            checks++;
            if (issued - k > 2) begin
                errors++;
                $display("FAIL bp_occupancy: got %0d outstanding expected at most 2", issued - k);
            end
            if (done === 1'b1) dc = c;
            pstall = out_valid && !out_ready;
            ppix = pixel;
            psof = sof;
            peol = eol;
        end
        checks++;
        if (k != N || issued != N || dc != last_hs + 1) begin
            errors++;
            $display("FAIL bp_frame_end: got pixels=%0d reads=%0d done_cycle=%0d expected 12 12 %0d", k, issued, dc, last_hs + 1);
        end
    endtask

    task automatic test_long_stall();
        int k = 0, early = 0, dc = -1;
        for (int c = 0; c < 30; c++) begin
            tick();
            start = c == 0;
            out_ready = !(c >= 2 && c < 12);
            @(negedge clk);
            if (c < 12 && mem_rd_en) early++;
            if (c >= 3 && c < 12) begin
                checks++;
                if (mem_rd_en !== 1'b0) begin
                    errors++;
                    $display("FAIL ls_no_read c=%0d: got %b expected 0", c, mem_rd_en);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (pixel !== DW'(k) || c != 12 + k) begin
                    errors++;
                    $display("FAIL ls_pixel c=%0d: got pix=%0d expected pix=%0d at c=%0d", c, pixel, k, 12 + k);
                end
                k++;
            end
            if (done === 1'b1) dc = c;
        end
        checks++;
        if (early != 2 || k != N || dc != 24) begin
            errors++;
            $display("FAIL ls_summary: got reads_before_resume=%0d pixels=%0d done_cycle=%0d expected 2 12 24", early, k, dc);
        end
    endtask

    task automatic test_start_busy();
        int k = 0, dn = 0, bz = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            start = c == 0 || c == 6;
            out_ready = 1'b1;
            @(negedge clk);
            if (out_valid && out_ready) begin
                checks++;
                if (pixel !== DW'(k)) begin
                    errors++;
                    $display("FAIL sb_pixel: got %0d expected %0d", pixel, k);
                end
                k++;
            end
            if (done === 1'b1) dn++;
            if (c >= 15 && busy) bz++;
        end
        start = 1'b0;
        checks++;
        if (k != N || dn != 1 || bz != 0) begin
            errors++;
            $display("FAIL sb_summary: got pixels=%0d dones=%0d late_busy=%0d expected 12 1 0", k, dn, bz);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0, dn = 0, dc = -1;
        for (int c = 0; c < 40 && k < 6; c++) begin
            tick();
            start = c == 0;
            out_ready = 1'b1;
            @(negedge clk);
            if (out_valid && out_ready) k++;
        end
        tick();
        start = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, mem_rd_en, out_valid, sof, eol, mem_addr, pixel} !== '0) begin
            errors++;
            $display("FAIL rm_outputs: got %h expected 0", {busy, done, mem_rd_en, out_valid, sof, eol, mem_addr, pixel});
        end
        tick();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            if (done === 1'b1 || out_valid === 1'b1 || busy === 1'b1) dn++;
        end
        checks++;
        if (dn != 0) begin
            errors++;
            $display("FAIL rm_aborted_quiet: got %0d active cycles expected 0", dn);
        end
        k = 0;
        dn = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            start = c == 0;
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (!(mem_rd_en === 1'b1 && mem_addr === '0)) begin
                    errors++;
                    $display("FAIL rm_restart_addr: got en=%b addr=%0d expected en=1 addr=0", mem_rd_en, mem_addr);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (pixel !== DW'(k) || c != 3 + k) begin
                    errors++;
                    $display("FAIL rm_pixel c=%0d: got %0d expected %0d at c=%0d", c, pixel, k, 3 + k);
                end
                k++;
            end
            if (done === 1'b1) begin
                dn++;
                dc = c;
            end
        end
        checks++;
        if (k != N || dn != 1 || dc != 15) begin
            errors++;
            $display("FAIL rm_frame_end: got pixels=%0d dones=%0d done_cycle=%0d expected 12 1 15", k, dn, dc);
        end
    endtask

    initial begin
        for (int a = 0; a < 2**AW; a++) mem[a] = DW'(a);
        test_reset();
        test_full_speed();
        test_backpressure();
        test_long_stall();
        test_start_busy();
        test_reset_mid();
        test_full_speed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
